// File: rtl/spill_stack.sv
// spill_stack: data/return stack with a small circular on-chip cache that
// spills its oldest entries to a memory backing store above a high-water mark
// and refills them below a low-water mark. The core sees an unbounded stack
// and is stalled only when the op it requests cannot be honoured this cycle.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no memory traffic; may issue a spill or fill on the next edge
//   SPILL | write of cache[bottom] to BASE+mem_level outstanding
//   FILL  | read of BASE+mem_level-1 outstanding, lands below cache bottom
module spill_stack #(
    parameter int              L    = 16,
    parameter int              DEP  = 2,
    parameter int              HI   = 2,
    parameter int              LO   = 2,
    parameter int              AW   = 16,
    parameter int              MEMN = 8,
    parameter logic [AW-1:0]   BASE = 16'h0100
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [L-1:0]               din,
    output logic [L-1:0]               dout,
    output logic                       stall,
    output logic [DEP:0]               level,
    output logic [$clog2(MEMN+1)-1:0]  mem_level,
    output logic                       ovf,
    output logic                       unf,
    input  logic                       clr,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [L-1:0]               mem_wdata,
    input  logic [L-1:0]               mem_rdata,
    input  logic                       mem_ack
);

    localparam int MLW = $clog2(MEMN+1);
    localparam int CAP = 2**DEP;

    localparam logic [DEP:0]   LVL_CAP   = (DEP+1)'(CAP);
    localparam logic [DEP:0]   LVL_CAPM1 = (DEP+1)'(CAP-1);
    localparam logic [DEP:0]   LVL_ONE   = (DEP+1)'(1);
    localparam logic [DEP:0]   LVL_HI    = (DEP+1)'(HI);
    localparam logic [DEP:0]   LVL_LO    = (DEP+1)'(LO);
    localparam logic [MLW-1:0] ML_FULL   = MLW'(MEMN);
    localparam logic [DEP-1:0] IDX_ONE   = DEP'(1);

    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    state_t          state;
    logic [L-1:0]    cache [CAP];
    logic [DEP-1:0]  bot;
    logic [DEP-1:0]  top_idx;
    logic [DEP-1:0]  bot_dn;
    logic [DEP-1:0]  wr_idx;
    logic [DEP:0]    level_nxt;

    logic push_only, pop_only, push_pop;
    logic lvl_zero, lvl_full, mem_empty, mem_full;
    logic do_write, inc, dec, set_ovf, set_unf;
    logic spill_ack, fill_ack;

    // With level==CAP the low bits wrap to 0, so top lands on bottom-1 as required.
    assign top_idx = bot + level[DEP-1:0] - IDX_ONE;
    assign bot_dn  = bot - IDX_ONE;

    assign push_only = push & ~pop;
    assign pop_only  = pop & ~push;
    assign push_pop  = push & pop;

    assign lvl_zero  = (level == '0);
    assign lvl_full  = (level == LVL_CAP);
    assign mem_empty = (mem_level == '0);
    assign mem_full  = (mem_level == ML_FULL);

    assign spill_ack = mem_req & mem_ack & (state == SPILL);
    assign fill_ack  = mem_req & mem_ack & (state == FILL);

    assign dout = lvl_zero ? '0 : cache[top_idx];

    // Stall whenever the op would need a cache slot or entry that memory traffic still owns.
    always_comb begin
        stall = 1'b0;
        if (pop & lvl_zero & ~mem_empty)
            stall = 1'b1;
        if (pop_only & (state == SPILL) & (level == LVL_ONE))
            stall = 1'b1;
        if (push_only & (state == FILL) & (level == LVL_CAPM1))
            stall = 1'b1;
        if (push_only & lvl_full & ~mem_full)
            stall = 1'b1;
    end

    // Decode the accepted op; push&pop on an empty cache degenerates to a plain push.
    always_comb begin
        do_write  = ~stall & push & ~(push_only & lvl_full);
        wr_idx    = (push_pop & ~lvl_zero) ? top_idx : (top_idx + IDX_ONE);
        inc       = ~stall & ((push_only & ~lvl_full) | (push_pop & lvl_zero));
        dec       = ~stall & pop_only & ~lvl_zero;
        set_ovf   = ~stall & push_only & lvl_full;
        set_unf   = ~stall & pop_only & lvl_zero;
        level_nxt = level + {{DEP{1'b0}}, inc} + {{DEP{1'b0}}, fill_ack}
                          - {{DEP{1'b0}}, dec} - {{DEP{1'b0}}, spill_ack};
    end

    // Cache storage: core writes land at/above top, fill data lands just below bottom.
    always_ff @(posedge clk) begin
        if (do_write)
            cache[wr_idx] <= din;
        if (fill_ack)
            cache[bot_dn] <= mem_rdata;
    end

    // Occupancy, sticky flags and the spill/fill sequencer with registered request outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            level     <= '0;
            mem_level <= '0;
            bot       <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
        end else begin
            level <= level_nxt;

            if (spill_ack) begin
                bot       <= bot + IDX_ONE;
                mem_level <= mem_level + MLW'(1);
            end else if (fill_ack) begin
                bot       <= bot_dn;
                mem_level <= mem_level - MLW'(1);
            end

            if (clr)
                ovf <= 1'b0;
            else if (set_ovf)
                ovf <= 1'b1;

            if (clr)
                unf <= 1'b0;
            else if (set_unf)
                unf <= 1'b1;

            case (state)
                IDLE: begin
                    if ((level > LVL_HI) && (mem_level < ML_FULL)) begin
                        state     <= SPILL;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE + AW'(mem_level);
                        mem_wdata <= cache[bot];
                    end else if ((level < LVL_LO) && !mem_empty) begin
                        state    <= FILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= BASE + AW'(mem_level) - AW'(1);
                    end
                end
                SPILL, FILL: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spill_stack.sv
// Testbench for spill_stack: table vectors, directed memory corner cases,
// then random traffic against a queue-based model of the unbounded stack.
module tb_spill_stack;

    localparam int          CAP  = 4;
    localparam int          HI   = 2;
    localparam int          LO   = 2;
    localparam int          MEMN = 8;
    localparam logic [15:0] BASE = 16'h0100;

    logic        clk, nreset, push, pop, clr, mem_ack;
    logic        stall, ovf, unf, mem_req, mem_we;
    logic [15:0] din, dout, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  level;
    logic [3:0]  mem_level;
    logic [15:0] tbmem [8];

    int   checks = 0;
    int   errors = 0;
    logic st_seen;
    logic [15:0] seen;

    // queue model: cq[0] is the cache bottom, cq[$] the top; bq[$] the newest spilled entry
    logic [15:0] cq[$];
    logic [15:0] bq[$];
    int          mst;
    logic        m_req, m_we, m_ovf, m_unf;
    logic [15:0] m_addr, m_wdata;

    spill_stack #(.L(16), .DEP(2), .HI(2), .LO(2), .AW(16), .MEMN(8), .BASE(16'h0100)) dut (
        .clk(clk), .nreset(nreset), .push(push), .pop(pop), .din(din), .dout(dout),
        .stall(stall), .level(level), .mem_level(mem_level), .ovf(ovf), .unf(unf),
        .clr(clr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb mem_rdata = tbmem[mem_addr[2:0]];

    always @(posedge clk)
        if (nreset && mem_req && mem_ack && mem_we)
            tbmem[mem_addr[2:0]] <= mem_wdata;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic c, input logic [15:0] d);
        @(negedge clk);
        push = p; pop = q; clr = c; din = d;
        #1 st_seen = stall;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic p, input logic q, input logic [15:0] d, output logic [15:0] sv);
        int n = 0;
        @(negedge clk);
        push = p; pop = q; clr = 1'b0; din = d;
        #1;
        while (stall && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (stall) begin
            checks++;
            errors++;
            $display("FAIL op_timeout at %0t: stall=%0b, required 0", $time, stall);
        end
        sv = dout;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
    endtask

    function automatic logic m_stall(input logic p, input logic q);
        int lvl = cq.size();
        int ml  = bq.size();
        return (q && lvl == 0 && ml > 0) ||
               (q && !p && mst == 1 && lvl == 1) ||
               (p && !q && mst == 2 && lvl == CAP-1) ||
               (p && !q && lvl == CAP && ml < MEMN);
    endfunction

    function automatic logic [15:0] m_dout();
        return (cq.size() > 0) ? cq[cq.size()-1] : 16'h0000;
    endfunction

    task automatic model_step(input logic p, input logic q, input logic c,
                              input logic [15:0] d, input logic a);
        int          lvl;
        int          ml;
        logic [15:0] bottom_v;
        logic [15:0] v;
        logic        st;
        logic        so, su;
        lvl      = cq.size();
        ml       = bq.size();
        bottom_v = (lvl > 0) ? cq[0] : 16'h0000;
        st       = m_stall(p, q);
        so       = 1'b0;
        su       = 1'b0;
        if (!st) begin
            if (p && q) begin
                if (lvl == 0) cq.push_back(d);
                else          cq[lvl-1] = d;
            end else if (p) begin
                if (lvl == CAP) so = 1'b1;
                else            cq.push_back(d);
            end else if (q) begin
                if (lvl == 0) su = 1'b1;
                else          void'(cq.pop_back());
            end
        end
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (so) m_ovf = 1'b1;
            if (su) m_unf = 1'b1;
        end
        if (m_req && a) begin
            if (m_we) begin
                bq.push_back(m_wdata);
                void'(cq.pop_front());
            end else begin
                v = bq.pop_back();
                cq.push_front(v);
            end
            m_req = 1'b0;
            mst   = 0;
        end else if (mst == 0) begin
            if (lvl > HI && ml < MEMN) begin
                m_req = 1'b1; m_we = 1'b1; m_addr = BASE + 16'(ml); m_wdata = bottom_v; mst = 1;
            end else if (lvl < LO && ml > 0) begin
                m_req = 1'b1; m_we = 1'b0; m_addr = BASE + 16'(ml - 1); mst = 2;
            end
        end
    endtask

    typedef struct {
        logic        push;
        logic        pop;
        logic        clr;
        logic [15:0] din;
        logic        exp_stall;
        logic [2:0]  exp_level;
        logic [15:0] exp_dout;
        logic        exp_ovf;
        logic        exp_unf;
        logic        exp_req;
    } vec_t;

    vec_t tv[10];

    initial begin
        logic hold;
        logic es;
        int   r;

        //          push  pop   clr   din       stall lvl   dout      ovf   unf   req
        tv[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 3'd1, 16'h1234, 1'b0, 1'b1, 1'b0};
        tv[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 3'd1, 16'h1234, 1'b0, 1'b0, 1'b0};
        tv[3] = '{1'b1, 1'b0, 1'b0, 16'h2222, 1'b0, 3'd2, 16'h2222, 1'b0, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0, 3'd2, 16'hAAAA, 1'b0, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1, 16'h1234, 1'b0, 1'b0, 1'b0};
        tv[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tv[7] = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
        tv[8] = '{1'b1, 1'b0, 1'b0, 16'h5A5A, 1'b0, 3'd1, 16'h5A5A, 1'b0, 1'b0, 1'b0};
        tv[9] = '{1'b1, 1'b1, 1'b0, 16'h6B6B, 1'b0, 3'd1, 16'h6B6B, 1'b0, 1'b0, 1'b0};

        nreset = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; din = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_mem_level", mem_level, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, BASE);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_ovf_unf", {ovf, unf}, 0);
        chk("rst_dout", dout, 0);
        @(negedge clk) nreset = 1'b1;

        // table vectors, no memory traffic involved
        for (int i = 0; i < 10; i++) begin
            step(tv[i].push, tv[i].pop, tv[i].clr, tv[i].din);
            chk($sformatf("tv%0d_stall", i), st_seen, tv[i].exp_stall);
            chk($sformatf("tv%0d_level", i), level, tv[i].exp_level);
            chk($sformatf("tv%0d_dout", i), dout, tv[i].exp_dout);
            chk($sformatf("tv%0d_ovf", i), ovf, tv[i].exp_ovf);
            chk($sformatf("tv%0d_unf", i), unf, tv[i].exp_unf);
            chk($sformatf("tv%0d_req", i), mem_req, tv[i].exp_req);
            chk($sformatf("tv%0d_mlevel", i), mem_level, 0);
        end

        // reset while a spill is outstanding (bottom entry is 6B6B)
        step(1'b1, 1'b0, 1'b0, 16'h1111);
        step(1'b1, 1'b0, 1'b0, 16'h2222);
        chk("rs_level3", level, 3);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("rs_req", mem_req, 1);
        chk("rs_we", mem_we, 1);
        chk("rs_addr", mem_addr, 16'h0100);
        chk("rs_wdata", mem_wdata, 16'h6B6B);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        chk("rs_req_drop", mem_req, 0);
        chk("rs_level0", level, 0);
        chk("rs_mlevel0", mem_level, 0);
        chk("rs_dout0", dout, 0);
        @(negedge clk) nreset = 1'b1;

        // spill with ack tied high
        mem_ack = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'h1111);
        step(1'b1, 1'b0, 1'b0, 16'h2222);
        step(1'b1, 1'b0, 1'b0, 16'h3333);
        chk("sp_level3", level, 3);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("sp_req", mem_req, 1);
        chk("sp_we", mem_we, 1);
        chk("sp_addr", mem_addr, 16'h0100);
        chk("sp_wdata", mem_wdata, 16'h1111);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("sp_level2", level, 2);
        chk("sp_mlevel1", mem_level, 1);
        chk("sp_dout", dout, 16'h3333);
        chk("sp_req_done", mem_req, 0);
        chk("sp_memword", tbmem[0], 16'h1111);

        // three pops with a slow fill
        mem_ack = 1'b0;
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("fl_pop1_level", level, 1);
        chk("fl_pop1_dout", dout, 16'h2222);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("fl_pop2_level", level, 0);
        chk("fl_req", mem_req, 1);
        chk("fl_we", mem_we, 0);
        chk("fl_addr", mem_addr, 16'h0100);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("fl_wait%0d_stall", k), stall, 1);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        #1;
        chk("fl_ack_stall", stall, 1);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("fl_ack_level", level, 1);
        chk("fl_ack_mlevel", mem_level, 0);
        chk("fl_ack_dout", dout, 16'h1111);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("fl_pop3_stall", st_seen, 0);
        chk("fl_pop3_level", level, 0);
        chk("fl_pop3_dout", dout, 0);
        chk("fl_pop3_mlevel", mem_level, 0);
        chk("fl_pop3_unf", unf, 0);

        // fill backing store and cache, then overflow and unwind
        mem_ack = 1'b1;
        for (int i = 0; i < 12; i++)
            do_op(1'b1, 1'b0, 16'h1000 + 16'(i), seen);
        repeat (10) step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("of_level4", level, 4);
        chk("of_mlevel8", mem_level, 8);
        chk("of_dout", dout, 16'h100B);
        step(1'b1, 1'b0, 1'b0, 16'h5555);
        chk("of_stall", st_seen, 0);
        chk("of_ovf", ovf, 1);
        chk("of_level", level, 4);
        chk("of_dout_keep", dout, 16'h100B);
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        chk("of_clr", ovf, 0);
        for (int i = 11; i >= 0; i--) begin
            do_op(1'b0, 1'b1, 16'h0000, seen);
            chk($sformatf("uw_pop%0d", i), seen, 16'h1000 + 16'(i));
        end
        repeat (6) step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("uw_level", level, 0);
        chk("uw_mlevel", mem_level, 0);
        chk("uw_unf", unf, 0);

        // random traffic against the queue model
        @(negedge clk);
        nreset = 1'b0; push = 1'b0; pop = 1'b0; clr = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        nreset = 1'b1;
        cq.delete(); bq.delete();
        mst = 0; m_req = 1'b0; m_we = 1'b0; m_addr = BASE; m_wdata = '0;
        m_ovf = 1'b0; m_unf = 1'b0;
        hold = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!hold) begin
                r = $urandom_range(0, 99);
                if (((cyc / 200) % 2) == 0) begin
                    push = (r < 65);
                    pop  = (r >= 50 && r < 80);
                end else begin
                    push = (r < 25);
                    pop  = (r >= 15 && r < 70);
                end
                din = 16'($urandom);
            end
            clr     = ($urandom_range(0, 29) == 0);
            mem_ack = ($urandom_range(0, 2) == 0);
            #1;
            es = m_stall(push, pop);
            chk("rnd_stall", stall, es);
            chk("rnd_level", level, cq.size());
            chk("rnd_mlevel", mem_level, bq.size());
            chk("rnd_dout", dout, m_dout());
            chk("rnd_ovf", ovf, m_ovf);
            chk("rnd_unf", unf, m_unf);
            chk("rnd_req", mem_req, m_req);
            if (m_req) begin
                chk("rnd_we", mem_we, m_we);
                chk("rnd_addr", mem_addr, m_addr);
                if (m_we)
                    chk("rnd_wdata", mem_wdata, m_wdata);
            end
            hold = es;
            model_step(push, pop, clr, din, mem_ack);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
